// File: rtl/area_ctrl_seq.sv
// area_ctrl_seq: accepts a control code plus repeat count, maps it through a
// run-time-writable decode table and streams the control word for rep+1 beats.
module area_ctrl_seq #(
  parameter int unsigned IN_W  = 7,
  parameter int unsigned OUT_W = 26,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IN_W-1:0]  cmd_code,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             tbl_we,
  input  logic [IN_W-1:0]  tbl_addr,
  input  logic [OUT_W-1:0] tbl_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_word,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DEPTH = 1 << IN_W;
  // Reset pattern: only the always-on strobe bit is set.
  localparam logic [OUT_W-1:0] RST_WORD = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    code_q, code_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   word_d;
  logic               valid_d, last_d, done_d, ready_d, busy_d;
  logic [OUT_W-1:0]   tbl_q [DEPTH];
  logic [OUT_W-1:0]   lookup_word_c;

  // Decode table storage; reset restores every entry and drops same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_q[i] <= RST_WORD;
      end
    end else if (tbl_we) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end

  // Write-first read of the latched code so a same-cycle write wins.
  assign lookup_word_c = (tbl_we && (tbl_addr == code_q)) ? tbl_data : tbl_q[code_q];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      rep_q     <= '0;
      cnt_q     <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      rep_q     <= rep_d;
      cnt_q     <= cnt_d;
      out_word  <= word_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      done      <= done_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    word_d  = out_word;
    valid_d = out_valid;
    last_d  = out_last;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          code_d  = cmd_code;
          rep_d   = cmd_rep;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        word_d  = lookup_word_c;
        cnt_d   = rep_q;
        last_d  = (rep_q == '0);
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Not last implies cnt_q > 0, so no wrap.
            cnt_d  = cnt_q - REP_W'(1);
            last_d = (cnt_q == REP_W'(1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_area_ctrl_seq.sv
// Directed bench for area_ctrl_seq: reset defaults, bursts, backpressure,
// write-first table lookup, max repeat and reset mid-burst.
module tb_area_ctrl_seq;

  localparam int unsigned IN_W  = 7;
  localparam int unsigned OUT_W = 26;
  localparam int unsigned REP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IN_W-1:0]  cmd_code;
  logic [REP_W-1:0] cmd_rep;
  logic             tbl_we;
  logic [IN_W-1:0]  tbl_addr;
  logic [OUT_W-1:0] tbl_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic             out_last;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  area_ctrl_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_rep(cmd_rep),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    cycle();
    tbl_we = 1'b0;
  endtask

  // Issue one command from IDLE; returns with the DUT in LOOKUP.
  task automatic send_cmd(input logic [IN_W-1:0] c, input logic [REP_W-1:0] r);
    check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_code = c; cmd_rep = r;
    cycle();
    cmd_valid = 1'b0;
    check("cmd_ready_in_lookup", 32'(cmd_ready), 32'd0);
    check("busy_in_lookup", 32'(busy), 32'd1);
    check("valid_in_lookup", 32'(out_valid), 32'd0);
  endtask

  // Drain a burst from LOOKUP using a repeating out_ready pattern (bit 0 first).
  // Optionally writes mid_data to mid_addr during the second EMIT cycle.
  task automatic run_burst(input int beats, input logic [OUT_W-1:0] word,
                           input logic [7:0] pat, input int patlen,
                           input logic mid_en, input logic [IN_W-1:0] mid_addr,
                           input logic [OUT_W-1:0] mid_data);
    int  got   = 0;
    int  dones = 0;
    bit  acc;
    cycle();
    tbl_we = 1'b0;
    check("valid_after_lookup", 32'(out_valid), 32'd1);
    for (int k = 0; k < 200 && dones == 0; k++) begin
      out_ready = pat[k % patlen];
      tbl_we    = mid_en && (k == 1);
      tbl_addr  = mid_addr;
      tbl_data  = mid_data;
      if (out_valid) begin
        check("beat_word", 32'(out_word), 32'(word));
        check("beat_last", 32'(out_last), 32'(got == beats - 1));
        check("cmd_ready_in_emit", 32'(cmd_ready), 32'd0);
      end
      acc = out_valid && out_ready;
      cycle();
      tbl_we = 1'b0;
      if (acc) got++;
      if (done) dones++;
    end
    out_ready = 1'b0;
    check("beat_count", 32'(got), 32'(beats));
    check("done_pulse", 32'(dones), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
    check("valid_at_done", 32'(out_valid), 32'd0);
    check("word_held", 32'(out_word), 32'(word));
    cycle();
    check("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_rep = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Reset-default table entry, single beat.
    send_cmd(7'd5, 4'd0);
    run_burst(1, 26'h2000000, 8'h01, 1, 1'b0, '0, '0);

    // Programmed entry, four beats at full rate.
    wr(7'h12, 26'h0ABCDEF);
    send_cmd(7'h12, 4'd3);
    run_burst(4, 26'h0ABCDEF, 8'h01, 1, 1'b0, '0, '0);

    // Same command under backpressure 0,0,1,0,1,1,0,1.
    send_cmd(7'h12, 4'd3);
    run_burst(4, 26'h0ABCDEF, 8'b1011_0100, 8, 1'b0, '0, '0);

    // Write-first in LOOKUP, then a mid-burst write that must not disturb the burst.
    send_cmd(7'd7, 4'd2);
    tbl_we = 1'b1; tbl_addr = 7'd7; tbl_data = 26'h155;
    run_burst(3, 26'h155, 8'h01, 1, 1'b1, 7'd7, 26'h2AA);
    send_cmd(7'd7, 4'd0);
    run_burst(1, 26'h2AA, 8'h01, 1, 1'b0, '0, '0);

    // Maximum repeat count: 16 beats.
    send_cmd(7'h12, 4'd15);
    run_burst(16, 26'h0ABCDEF, 8'h01, 1, 1'b0, '0, '0);

    // Reset during beat 2 of a six-beat burst, with a write in the reset cycle.
    send_cmd(7'h12, 4'd5);
    cycle();
    out_ready = 1'b1;
    check("mid_valid_beat1", 32'(out_valid), 32'd1);
    cycle();
    check("mid_valid_beat2", 32'(out_valid), 32'd1);
    rst = 1'b1; tbl_we = 1'b1; tbl_addr = 7'h12; tbl_data = 26'h3FFFFFF;
    cycle();
    rst = 1'b0; tbl_we = 1'b0; out_ready = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    cycle();
    check("abort_done_later", 32'(done), 32'd0);

    // Table restored to the reset pattern, including the top address.
    send_cmd(7'h12, 4'd0);
    run_burst(1, 26'h2000000, 8'h01, 1, 1'b0, '0, '0);
    send_cmd(7'd7, 4'd1);
    run_burst(2, 26'h2000000, 8'h01, 1, 1'b0, '0, '0);
    send_cmd(7'h7F, 4'd0);
    run_burst(1, 26'h2000000, 8'h01, 1, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
